// File: rtl/digit_scan_mux.sv
// -----------------------------------------------------------------------------
// digit_scan_mux
//
// Time-multiplexed scanner for a multi-digit seven-segment display. A
// prescaler divides the clock into digit slots of REFRESH_DIV cycles. In each
// slot one digit is presented, with a one-cold anode enable. The first
// BLANK_CYCLES of every slot keep all anodes off, which prevents ghosting
// while the segment lines settle. A frame is one pass over all digits. Digits
// flagged in blink_mask are suppressed during alternate groups of
// BLINK_FRAMES frames.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous reset, active high
//   en           scan enable; when low the scan position holds and the anodes
//                are off
//   digits_in    packed digit values, digit i at [i*DIGIT_W +: DIGIT_W]
//   blink_mask   1 = digit i blinks
//   dp_mask      1 = decimal point lit on digit i
//   digit_out    registered value of the selected digit
//   an_n         registered anode enables, active low, at most one low
//   dp_n         registered decimal point, active low
//   sel          index of the current digit slot
//   frame_start  one-cycle pulse after the edge on which sel wraps to 0
// -----------------------------------------------------------------------------
module digit_scan_mux #(
    parameter int NUM_DIGITS   = 4,
    parameter int DIGIT_W      = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 2000,
    parameter int BLINK_FRAMES = 64,
    localparam int SEL_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [NUM_DIGITS*DIGIT_W-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]         blink_mask,
    input  logic [NUM_DIGITS-1:0]         dp_mask,
    output logic [DIGIT_W-1:0]            digit_out,
    output logic [NUM_DIGITS-1:0]         an_n,
    output logic                          dp_n,
    output logic [SEL_W-1:0]              sel,
    output logic                          frame_start
);

    localparam int PC_W = $clog2(REFRESH_DIV);
    localparam int BC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [PC_W-1:0]  PC_LAST  = PC_W'(REFRESH_DIV - 1);
    localparam logic [PC_W-1:0]  PC_BLANK = PC_W'(BLANK_CYCLES);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_DIGITS - 1);
    localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(BLINK_FRAMES - 1);

    logic [PC_W-1:0]       pc;
    logic [BC_W-1:0]       blink_cnt;
    logic                  blink_phase;

    logic                  slot_end;
    logic                  frame_end;
    logic                  active;
    logic [DIGIT_W-1:0]    digit_sel;
    logic [NUM_DIGITS-1:0] an_next;

    assign slot_end  = (pc == PC_LAST);
    assign frame_end = slot_end && (sel == SEL_LAST);

    // Scan position and blink state advance only while enabled.
    // NOTE: all sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= '0;
            sel         <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (en) begin
            if (slot_end) begin
                pc <= '0;
                if (sel == SEL_LAST) begin
                    sel <= '0;
                    // Frame boundary: count it, toggle the phase on the last one.
                    if (blink_cnt == BC_LAST) begin
                        blink_cnt   <= '0;
                        blink_phase <= ~blink_phase;
                    end else begin
                        blink_cnt <= blink_cnt + 1'b1;
                    end
                end else begin
                    sel <= sel + 1'b1;
                end
            end else begin
                pc <= pc + 1'b1;
            end
        end
    end

    // Output values for the current slot position.
    // NOTE: every variable written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        digit_sel = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel == SEL_W'(i)) begin
                digit_sel = digits_in[i*DIGIT_W +: DIGIT_W];
            end
        end

        active = en && (pc >= PC_BLANK) && !(blink_phase && blink_mask[sel]);

        an_next = '1;
        if (active) begin
            an_next[sel] = 1'b0;
        end
    end

    // Display outputs are registered every cycle, whether or not the scan is
    // enabled, so disabling blanks the anodes one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_out   <= '0;
            an_n        <= '1;
            dp_n        <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            digit_out   <= digit_sel;
            an_n        <= an_next;
            dp_n        <= !(active && dp_mask[sel]);
            frame_start <= en && frame_end;
        end
    end

endmodule

// File: tb/tb_digit_scan_mux.sv
// -----------------------------------------------------------------------------
// tb_digit_scan_mux
//
// Bench for digit_scan_mux with small parameters: 4 digits, 8-cycle slots,
// 2 blanking cycles, and 2 frames per blink half-period. A reference model
// derives the expected outputs from a count of enabled cycles. A compare
// process checks the DUT against that model on every falling edge. Directed
// scenarios also pin hand-computed values.
// -----------------------------------------------------------------------------
module tb_digit_scan_mux;

    localparam int ND = 4;
    localparam int DW = 4;
    localparam int RD = 8;
    localparam int BC = 2;
    localparam int BF = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               en  = 1'b0;
    logic [ND*DW-1:0]   digits_in  = 16'h4321;
    logic [ND-1:0]      blink_mask = '0;
    logic [ND-1:0]      dp_mask    = '0;
    logic [DW-1:0]      digit_out;
    logic [ND-1:0]      an_n;
    logic               dp_n;
    logic [1:0]         sel;
    logic               frame_start;

    int errors = 0;
    int checks = 0;

    digit_scan_mux #(
        .NUM_DIGITS  (ND),
        .DIGIT_W     (DW),
        .REFRESH_DIV (RD),
        .BLANK_CYCLES(BC),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .digits_in  (digits_in),
        .blink_mask (blink_mask),
        .dp_mask    (dp_mask),
        .digit_out  (digit_out),
        .an_n       (an_n),
        .dp_n       (dp_n),
        .sel        (sel),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // n counts enabled cycles since reset. Slot, digit index, blanking and
    // blink phase all follow from n by division.
    int   n = 0;
    bit   model_ok = 0;
    int   exp_digit, exp_an, exp_dp, exp_sel, exp_fs;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            n         = 0;
            model_ok  = 1;
            exp_digit = 0;
            exp_an    = 4'hF;
            exp_dp    = 1;
            exp_sel   = 0;
            exp_fs    = 0;
        end else begin
            int d, p, frame, phase;
            bit lit;
            d     = (n / RD) % ND;
            p     = n % RD;
            frame = n / (RD * ND);
            phase = (frame / BF) % 2;
            lit   = en && (p >= BC) && !(phase == 1 && blink_mask[d]);
            exp_digit = (digits_in >> (d * DW)) & 4'hF;
            exp_an    = lit ? (~(1 << d) & 4'hF) : 4'hF;
            exp_dp    = (lit && dp_mask[d]) ? 0 : 1;
            exp_fs    = (en && p == RD - 1 && d == ND - 1) ? 1 : 0;
            if (en) n = n + 1;
            exp_sel   = (n / RD) % ND;
        end
    end

    always @(negedge clk) begin
        if (!rst && model_ok) begin
            check("model digit_out",   digit_out,   exp_digit);
            check("model an_n",        an_n,        exp_an);
            check("model dp_n",        dp_n,        exp_dp);
            check("model sel",         sel,         exp_sel);
            check("model frame_start", frame_start, exp_fs);
        end
    end

    // ---------------- stimulus helpers ----------------
    // Inputs change on falling edges; after step() returns, the outputs of
    // the edge just taken are visible.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        step();
        check("rst an_n",        an_n,        4'hF);
        check("rst digit_out",   digit_out,   0);
        check("rst sel",         sel,         0);
        check("rst dp_n",        dp_n,        1);
        check("rst frame_start", frame_start, 0);
        step();
        rst = 1'b0;
    endtask

    int fs_cnt, cnt1011[8], cnt1110_f2, dp_bad, dp_low;
    logic [3:0] an_hist[256];

    initial begin
        // ---- reset / startup ----
        en = 1'b1;
        do_reset();
        for (int k = 1; k <= 11; k++) begin
            step();
            if (k <= 2) begin
                check("start blank an_n", an_n, 4'hF);
                check("start digit_out",  digit_out, 1);
            end else if (k <= 8) begin
                check("slot0 an_n", an_n, 4'hE);
            end else if (k == 9) begin
                check("slot1 blank an_n",    an_n, 4'hF);
                check("slot1 digit_out",     digit_out, 2);
            end else if (k == 11) begin
                check("slot1 an_n", an_n, 4'hD);
            end
        end

        // ---- full scan ----
        do_reset();
        fs_cnt = 0;
        for (int k = 1; k <= 64; k++) begin
            step();
            if (frame_start) fs_cnt++;
            if (k == 24) check("scan sel at 24", sel, 3);
            if (k == 32) begin
                check("scan fs at 32",    frame_start, 1);
                check("scan digit at 32", digit_out, 4);
            end
            if (k == 33) check("scan digit at 33", digit_out, 1);
        end
        check("scan frame_start count", fs_cnt, 2);

        // ---- input change mid-slot ----
        digits_in = 16'h8765;
        step();
        check("new digits digit_out", digit_out, 5);
        digits_in = 16'h4321;

        // ---- blink ----
        blink_mask = 4'b0100;
        do_reset();
        for (int k = 1; k <= 256; k++) begin
            step();
            an_hist[k-1] = an_n;
        end
        for (int f = 0; f < 8; f++) begin
            cnt1011[f] = 0;
            for (int c = 0; c < 32; c++)
                if (an_hist[f*32 + c] == 4'b1011) cnt1011[f]++;
        end
        cnt1110_f2 = 0;
        for (int c = 0; c < 32; c++)
            if (an_hist[64 + c] == 4'b1110) cnt1110_f2++;
        check("blink frame0", cnt1011[0], 6);
        check("blink frame1", cnt1011[1], 6);
        check("blink frame2", cnt1011[2], 0);
        check("blink frame3", cnt1011[3], 0);
        check("blink frame4", cnt1011[4], 6);
        check("blink frame5", cnt1011[5], 6);
        check("blink frame6", cnt1011[6], 0);
        check("blink frame7", cnt1011[7], 0);
        check("blink other digit frame2", cnt1110_f2, 6);
        blink_mask = '0;

        // ---- decimal point ----
        dp_mask = 4'b0001;
        do_reset();
        dp_bad = 0;
        dp_low = 0;
        for (int k = 1; k <= 64; k++) begin
            step();
            if (dp_n == 1'b0) dp_low++;
            if ((dp_n == 1'b0) != (an_n == 4'b1110)) dp_bad++;
        end
        check("dp low count", dp_low, 12);
        check("dp vs an_n",   dp_bad, 0);

        // ---- enable gap ----
        dp_mask = 4'b0100;
        do_reset();
        repeat (21) step();
        check("gap pre an_n", an_n, 4'hB);
        check("gap pre dp_n", dp_n, 0);
        en = 1'b0;
        for (int k = 22; k <= 31; k++) begin
            step();
            check("gap an_n", an_n, 4'hF);
            check("gap dp_n", dp_n, 1);
            check("gap sel",  sel, 2);
            check("gap fs",   frame_start, 0);
        end
        en = 1'b1;
        step();
        check("resume an_n", an_n, 4'hB);
        step();
        check("resume sel 33", sel, 2);
        step();
        check("resume sel 34", sel, 3);
        dp_mask = '0;

        // ---- async reset mid-slot ----
        do_reset();
        repeat (11) step();
        check("pre-async an_n", an_n, 4'hD);
        #1;
        rst = 1'b1;
        #1;
        check("async an_n",      an_n, 4'hF);
        check("async digit_out", digit_out, 0);
        check("async sel",       sel, 0);
        step();
        rst = 1'b0;
        step();
        check("restart an_n",      an_n, 4'hF);
        check("restart digit_out", digit_out, 1);
        step();
        step();
        check("restart slot0 an_n", an_n, 4'hE);

        repeat (4) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
